// File: rtl/keypad_pkg.sv
// Shared keypad definitions: key-index mapping and scan/synchroniser constants.
package keypad_pkg;

  // Number of flops between the raw row pins and any use of the row value.
  localparam int SYNC_DEPTH = 2;

  // Smallest dwell that still gives the synchroniser time to settle
  // before the sample taken on the last dwell cycle.
  localparam int MIN_SCAN_DIV = 4;

  // Bitmap position of key (r, c): row0/col0 lands on the MSB,
  // the last row/last column on bit 0.
  function automatic int key_index(input int r, input int c,
                                   input int n_col, input int n_row);
    return n_col * n_row - 1 - (r * n_col + c);
  endfunction

endpackage

// File: rtl/keypad_scan_debounce_row_sync.sv
// Parameterised-width multi-flop synchroniser for the asynchronous row inputs.
module row_sync
  import keypad_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] stage_q [SYNC_DEPTH];

  // Shift the raw value through the synchroniser chain; reset clears every stage.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < SYNC_DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < SYNC_DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[SYNC_DEPTH-1];

endmodule

// File: rtl/keypad_scan_debounce.sv
// Matrix keypad scanner: drives one column at a time, samples the synchronised
// rows on the last dwell cycle, and publishes a whole-frame bitmap once it has
// been identical for DEBOUNCE_SCANS consecutive frames.
//
// Output protocol: data_valid is a one-cycle strobe with no back-pressure.
// out_keys changes only on the edge that raises data_valid and holds until
// the next strobe. A stable keypad (including all keys open) strobes once per
// frame, so a release shows up as a strobe carrying an all-zero bitmap.
module keypad_scan_debounce
  import keypad_pkg::*;
#(
  parameter int N_COLUMN       = 4,
  parameter int N_ROW          = 4,
  parameter int SCAN_DIV       = 20000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic [N_COLUMN-1:0]       column,
  input  logic [N_ROW-1:0]          row,
  output logic [N_COLUMN*N_ROW-1:0] out_keys,
  output logic                      data_valid
);

  localparam int KEYS = N_COLUMN * N_ROW;
  localparam int DW   = $clog2(SCAN_DIV);
  localparam int CW   = (N_COLUMN > 1) ? $clog2(N_COLUMN) : 1;
  localparam int SW   = $clog2(DEBOUNCE_SCANS + 1);

  if (SCAN_DIV < MIN_SCAN_DIV) begin : g_bad_scan_div
    $error("SCAN_DIV too small for the row synchroniser to settle");
  end
  if (DEBOUNCE_SCANS < 1) begin : g_bad_debounce
    $error("DEBOUNCE_SCANS must be at least 1");
  end

  logic [DW-1:0]    dwell_q;
  logic [CW-1:0]    col_q;
  logic [N_ROW-1:0] row_s;
  logic [KEYS-1:0]  frame_q, frame_d;
  logic [KEYS-1:0]  prev_q;
  logic [SW-1:0]    stable_cnt_q, stable_cnt_d;
  logic [KEYS-1:0]  out_keys_q;
  logic             data_valid_q;

  logic sample;
  logic frame_end;
  logic publish;

  row_sync #(.W(N_ROW)) u_row_sync (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (row),
    .q_o   (row_s)
  );

  assign sample    = (dwell_q == DW'(SCAN_DIV - 1));
  assign frame_end = sample && (col_q == CW'(N_COLUMN - 1));
  assign column    = N_COLUMN'(1) << col_q;

  // Frame as it would look after overwriting the current column's bits with the sampled rows.
  always_comb begin
    frame_d = frame_q;
    for (int c = 0; c < N_COLUMN; c++) begin
      if (col_q == CW'(c)) begin
        for (int r = 0; r < N_ROW; r++) begin
          frame_d[key_index(r, c, N_COLUMN, N_ROW)] = row_s[r];
        end
      end
    end
  end

  // Debounce count for a completed frame: extend a matching run (saturating) or restart it.
  always_comb begin
    stable_cnt_d = SW'(1);
    if (frame_d == prev_q) begin
      if (stable_cnt_q >= SW'(DEBOUNCE_SCANS)) stable_cnt_d = SW'(DEBOUNCE_SCANS);
      else                                     stable_cnt_d = stable_cnt_q + 1'b1;
    end
  end

  assign publish = frame_end && (stable_cnt_d >= SW'(DEBOUNCE_SCANS));

  // Scan state (column index, dwell), frame capture, debounce history and published bitmap.
  always_ff @(posedge clk) begin
    if (rst) begin
      dwell_q      <= '0;
      col_q        <= '0;
      frame_q      <= '0;
      prev_q       <= '0;
      stable_cnt_q <= '0;
      out_keys_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      data_valid_q <= publish;
      if (sample) begin
        dwell_q <= '0;
        col_q   <= (col_q == CW'(N_COLUMN - 1)) ? '0 : col_q + 1'b1;
        frame_q <= frame_d;
      end else begin
        dwell_q <= dwell_q + 1'b1;
      end
      if (frame_end) begin
        prev_q       <= frame_d;
        stable_cnt_q <= stable_cnt_d;
      end
      if (publish) out_keys_q <= frame_d;
    end
  end

  assign out_keys   = out_keys_q;
  assign data_valid = data_valid_q;

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Directed bench for keypad_scan_debounce on a 4x4 keypad, SCAN_DIV=4, DEBOUNCE_SCANS=3.
module tb_keypad_scan_debounce;

  localparam int NC = 4;
  localparam int NR = 4;

  logic          clk;
  logic          rst;
  logic [NC-1:0] column;
  logic [NR-1:0] row;
  logic [15:0]   out_keys;
  logic          data_valid;

  logic [15:0]   press_q;   // keypad model: bit set = key closed

  int n_vec;
  int n_err;

  typedef struct {
    logic [15:0] press;
    logic        exp_dv;
    logic [15:0] exp_keys;
  } vec_t;

  vec_t tbl [21];

  keypad_scan_debounce #(
    .N_COLUMN       (NC),
    .N_ROW          (NR),
    .SCAN_DIV       (4),
    .DEBOUNCE_SCANS (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .column     (column),
    .row        (row),
    .out_keys   (out_keys),
    .data_valid (data_valid)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad model: row r is high when the driven column has a closed key in row r.
  always_comb begin
    row = '0;
    for (int r = 0; r < NR; r++) begin
      for (int c = 0; c < NC; c++) begin
        if (column[c] && press_q[15 - (r * 4 + c)]) row[r] = 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Runs one 16-cycle frame starting at the negedge of its first cycle, then
  // checks the strobe and bitmap at the negedge of the next frame's first cycle.
  task automatic run_frame(input logic [15:0] press, input logic exp_dv, input logic [15:0] exp_keys);
    int          col_bad;
    int          dv_bad;
    int          keys_bad;
    logic [3:0]  exp_col;
    logic [15:0] held;
    press_q  = press;
    col_bad  = 0;
    dv_bad   = 0;
    keys_bad = 0;
    held     = out_keys;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      exp_col = 4'b0001 << (i / 4);
      if (column !== exp_col) col_bad++;
      if (i > 0 && data_valid !== 1'b0) dv_bad++;
      if (out_keys !== held) keys_bad++;
    end
    @(negedge clk);
    check("column_seq_errs", 32'(col_bad), 32'd0);
    check("midframe_strobes", 32'(dv_bad), 32'd0);
    check("midframe_key_changes", 32'(keys_bad), 32'd0);
    check("data_valid", {31'd0, data_valid}, {31'd0, exp_dv});
    check("out_keys", {16'd0, out_keys}, {16'd0, exp_keys});
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    press_q = '0;

    // idle keypad: first strobe after the third frame end
    tbl[0]  = '{16'h0000, 1'b0, 16'h0000};
    tbl[1]  = '{16'h0000, 1'b0, 16'h0000};
    tbl[2]  = '{16'h0000, 1'b1, 16'h0000};
    tbl[3]  = '{16'h0000, 1'b1, 16'h0000};
    // row0/col0 pressed, then released
    tbl[4]  = '{16'h8000, 1'b0, 16'h0000};
    tbl[5]  = '{16'h8000, 1'b0, 16'h0000};
    tbl[6]  = '{16'h8000, 1'b1, 16'h8000};
    tbl[7]  = '{16'h8000, 1'b1, 16'h8000};
    tbl[8]  = '{16'h0000, 1'b0, 16'h8000};
    tbl[9]  = '{16'h0000, 1'b0, 16'h8000};
    tbl[10] = '{16'h0000, 1'b1, 16'h0000};
    // row2/col1 with a one-frame bounce open
    tbl[11] = '{16'h0040, 1'b0, 16'h0000};
    tbl[12] = '{16'h0000, 1'b0, 16'h0000};
    tbl[13] = '{16'h0040, 1'b0, 16'h0000};
    tbl[14] = '{16'h0040, 1'b0, 16'h0000};
    tbl[15] = '{16'h0040, 1'b1, 16'h0040};
    tbl[16] = '{16'h0040, 1'b1, 16'h0040};
    // row0/col3 + row3/col3 together
    tbl[17] = '{16'h1001, 1'b0, 16'h0040};
    tbl[18] = '{16'h1001, 1'b0, 16'h0040};
    tbl[19] = '{16'h1001, 1'b1, 16'h1001};
    tbl[20] = '{16'h1001, 1'b1, 16'h1001};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_out_keys", {16'd0, out_keys}, 32'd0);
    check("reset_data_valid", {31'd0, data_valid}, 32'd0);
    check("reset_column", {28'd0, column}, 32'd1);
    rst = 1'b0;

    for (int v = 0; v < 21; v++) begin
      run_frame(tbl[v].press, tbl[v].exp_dv, tbl[v].exp_keys);
    end

    // Mid-frame reset while row0/col0 is held and published.
    run_frame(16'h8000, 1'b0, 16'h1001);
    run_frame(16'h8000, 1'b0, 16'h1001);
    run_frame(16'h8000, 1'b1, 16'h8000);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midreset_out_keys", {16'd0, out_keys}, 32'd0);
    check("midreset_data_valid", {31'd0, data_valid}, 32'd0);
    check("midreset_column", {28'd0, column}, 32'd1);
    rst = 1'b0;
    run_frame(16'h8000, 1'b0, 16'h0000);
    run_frame(16'h8000, 1'b0, 16'h0000);
    run_frame(16'h8000, 1'b1, 16'h8000);

    // Long hold: one strobe per frame, bitmap constant, counter saturated.
    for (int f = 0; f < 1000; f++) begin
      run_frame(16'h8000, 1'b1, 16'h8000);
    end
    check("stable_cnt_saturated", 32'(dut.stable_cnt_q), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
